// File: rtl/csr_access_ctrl_if.sv
// Request/response/register-file bundle for the CSR access controller.
// The slave modport is the controller; the master modport is its environment.
interface csr_access_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              p_req_valid;
    logic              p_req_ready;
    logic [1:0]        p_req_op;
    logic [ADDR_W-1:0] p_req_addr;
    logic [DATA_W-1:0] p_req_wdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [1:0]        d_req_op;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_din;
    logic              csr_wrt_en;
    logic [DATA_W-1:0] csr_dout;

    modport slave (
        input  p_req_valid, p_req_op, p_req_addr, p_req_wdata,
        output p_req_ready,
        input  d_req_valid, d_req_op, d_req_addr, d_req_wdata,
        output d_req_ready,
        output resp_valid, resp_id, resp_rdata, resp_err,
        input  resp_ready,
        output csr_addr, csr_din, csr_wrt_en,
        input  csr_dout
    );

    modport master (
        output p_req_valid, p_req_op, p_req_addr, p_req_wdata,
        input  p_req_ready,
        output d_req_valid, d_req_op, d_req_addr, d_req_wdata,
        input  d_req_ready,
        input  resp_valid, resp_id, resp_rdata, resp_err,
        output resp_ready,
        input  csr_addr, csr_din, csr_wrt_en,
        output csr_dout
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Arbitrates pipeline/debug CSR requests and performs read-modify-write
// accesses on an external register file, one access at a time.
module csr_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    csr_access_ctrl_if.slave  bus,
    output logic              busy,
    output logic [7:0]        err_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t            state_q;
    logic              last_dbg_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              id_q;
    logic              illegal_q;
    logic              wrt_en_q;
    logic              resp_valid_q;
    logic              resp_id_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic [7:0]        err_cnt_q;

    logic              p_grant, d_grant, accept;
    logic [1:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_wen, sel_ro;

    function automatic logic [DATA_W-1:0] apply_op(input logic [1:0] op,
                                                   input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wd);
        case (op)
            OP_RW:   return wd;
            OP_RS:   return old | wd;
            OP_RC:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Debug wins a conflict only when the pipeline was granted last.
    always_comb begin
        p_grant   = reset && (state_q == IDLE) && bus.p_req_valid &&
                    (!bus.d_req_valid || last_dbg_q);
        d_grant   = reset && (state_q == IDLE) && bus.d_req_valid && !p_grant;
        accept    = p_grant || d_grant;
        sel_op    = d_grant ? bus.d_req_op    : bus.p_req_op;
        sel_addr  = d_grant ? bus.d_req_addr  : bus.p_req_addr;
        sel_wdata = d_grant ? bus.d_req_wdata : bus.p_req_wdata;
        sel_wen   = (sel_op == OP_RW) || (sel_op[1] && (sel_wdata != '0));
        sel_ro    = (sel_addr[11:10] == 2'b11);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_dbg_q   <= 1'b1;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            id_q         <= 1'b0;
            illegal_q    <= 1'b0;
            wrt_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= EXEC;
                        last_dbg_q <= d_grant;
                        op_q       <= sel_op;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        id_q       <= d_grant;
                        illegal_q  <= sel_wen && sel_ro;
                        wrt_en_q   <= sel_wen && !sel_ro;
                    end
                end
                // Read and write share this cycle, so rdata is the pre-write value.
                EXEC: begin
                    state_q      <= RESP;
                    wrt_en_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_id_q    <= id_q;
                    resp_rdata_q <= bus.csr_dout;
                    resp_err_q   <= illegal_q;
                    if (illegal_q) err_cnt_q <= sat_inc(err_cnt_q);
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.p_req_ready = p_grant;
    assign bus.d_req_ready = d_grant;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.csr_addr    = addr_q;
    assign bus.csr_wrt_en  = wrt_en_q;
    assign bus.csr_din     = (state_q == EXEC) ? apply_op(op_q, bus.csr_dout, wdata_q) : '0;
    assign busy            = (state_q != IDLE);
    assign err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed testbench for csr_access_ctrl with a behavioural register file.
module tb_csr_access_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_count = 0;
    logic [31:0] last_din = '0;

    always #5 clk = ~clk;

    csr_access_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    assign bus.csr_dout = rf[bus.csr_addr];

    csr_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end else if (bus.csr_wrt_en) begin
            rf[bus.csr_addr] <= bus.csr_din;
            wr_count         <= wr_count + 1;
            last_din         <= bus.csr_din;
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request from one side and completes its response handshake.
    task automatic run_req(input bit dbg, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err,
                           output logic rid, output int lat, output bit to);
        bit got = 1'b0;
        to = 1'b0; lat = 1; rd = '0; err = 1'b0; rid = 1'b0;
        if (dbg) begin
            bus.d_req_valid = 1'b1; bus.d_req_op = op; bus.d_req_addr = addr; bus.d_req_wdata = wd;
        end else begin
            bus.p_req_valid = 1'b1; bus.p_req_op = op; bus.p_req_addr = addr; bus.p_req_wdata = wd;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dbg ? bus.d_req_ready : bus.p_req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.p_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        if (!got) begin
            to = 1'b1;
            return;
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid) break;
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) begin
            to = 1'b1;
            return;
        end
        rd = bus.resp_rdata; err = bus.resp_err; rid = bus.resp_id;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.p_req_valid = 1'b1; bus.p_req_op = 2'b00; bus.p_req_addr = 12'h010; bus.p_req_wdata = '0;
        #1;
        n_checks++; if (bus.p_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_p_ready: got %b expected 0", bus.p_req_ready); end
        n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_id !== 1'b0 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_ctrl: got v%b id%b e%b expected 000", bus.resp_valid, bus.resp_id, bus.resp_err); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", bus.resp_rdata); end
        n_checks++; if (bus.csr_wrt_en !== 1'b0 || bus.csr_addr !== 12'h0 || bus.csr_din !== 32'h0) begin n_fail++; $display("FAIL rst_csr: got we%b a%h d%h expected 0", bus.csr_wrt_en, bus.csr_addr, bus.csr_din); end
        n_checks++; if (busy !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_busy_cnt: got %b/%0d expected 0/0", busy, err_cnt); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (bus.p_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 1", bus.p_req_ready); end
        @(negedge clk);
        bus.p_req_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || bus.csr_addr !== 12'h010 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec: got busy%b a%h v%b expected 1/010/0", busy, bus.csr_addr, bus.resp_valid); end
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1111_0010) begin n_fail++; $display("FAIL rst_first_resp: got v%b %h expected 1 11110010", bus.resp_valid, bus.resp_rdata); end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_back_idle: got v%b busy%b expected 0/0", bus.resp_valid, busy); end
    endtask

    task automatic test_rs_collision();
        logic [31:0] rd; logic err, rid; int lat; bit to; int w0;
        w0 = wr_count;
        run_req(1'b0, 2'b10, 12'h300, 32'h80, rd, err, rid, lat, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rs_timeout: got %b expected 0", to); end
        n_checks++; if (rd !== 32'h8 || err !== 1'b0 || rid !== 1'b0) begin n_fail++; $display("FAIL rs_resp: got %h e%b id%b expected 00000008 0 0", rd, err, rid); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rs_latency: got %0d expected 2", lat); end
        n_checks++; if (wr_count - w0 !== 1 || last_din !== 32'h88) begin n_fail++; $display("FAIL rs_write: got %0d writes din %h expected 1 00000088", wr_count - w0, last_din); end
        n_checks++; if (rf[12'h300] !== 32'h88) begin n_fail++; $display("FAIL rs_rf: got %h expected 00000088", rf[12'h300]); end
    endtask

    task automatic test_ops();
        logic [31:0] rd; logic err, rid; int lat; bit to; int w0;
        w0 = wr_count;
        run_req(1'b0, 2'b01, 12'h100, 32'h1234, rd, err, rid, lat, to);
        n_checks++; if (to || rd !== 32'hFFFF || wr_count - w0 !== 1 || last_din !== 32'h1234) begin n_fail++; $display("FAIL rw_op: got to%b %h %0d writes din %h expected 0 0000ffff 1 00001234", to, rd, wr_count - w0, last_din); end
        w0 = wr_count;
        run_req(1'b1, 2'b11, 12'h100, 32'h0204, rd, err, rid, lat, to);
        n_checks++; if (to || rd !== 32'h1234 || rid !== 1'b1 || wr_count - w0 !== 1 || last_din !== 32'h1030) begin n_fail++; $display("FAIL rc_op: got to%b %h id%b %0d writes din %h expected 0 00001234 1 1 00001030", to, rd, rid, wr_count - w0, last_din); end
        w0 = wr_count;
        run_req(1'b0, 2'b00, 12'h100, 32'hFFFF_FFFF, rd, err, rid, lat, to);
        n_checks++; if (to || rd !== 32'h1030 || err !== 1'b0 || wr_count - w0 !== 0) begin n_fail++; $display("FAIL rd_op: got to%b %h e%b %0d writes expected 0 00001030 0 0", to, rd, err, wr_count - w0); end
        w0 = wr_count;
        run_req(1'b0, 2'b11, 12'h100, 32'h0, rd, err, rid, lat, to);
        n_checks++; if (to || rd !== 32'h1030 || wr_count - w0 !== 0) begin n_fail++; $display("FAIL rc_zero: got to%b %h %0d writes expected 0 00001030 0", to, rd, wr_count - w0); end
    endtask

    task automatic test_arbitration();
        int g[8]; int ng = 0; int nr = 0; int overlap = 0;
        for (int k = 0; k < 8; k++) g[k] = -1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.p_req_valid = 1'b1; bus.p_req_op = 2'b00; bus.p_req_addr = 12'h010; bus.p_req_wdata = '0;
        bus.d_req_valid = 1'b1; bus.d_req_op = 2'b00; bus.d_req_addr = 12'h020; bus.d_req_wdata = '0;
        bus.resp_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (bus.resp_valid && nr < 8) begin
                n_checks++; if (bus.resp_id !== g[nr][0]) begin n_fail++; $display("FAIL arb_resp_id[%0d]: got %b expected %0d", nr, bus.resp_id, g[nr]); end
                n_checks++; if (bus.resp_rdata !== (g[nr] == 1 ? 32'h2222_0020 : 32'h1111_0010)) begin n_fail++; $display("FAIL arb_rdata[%0d]: got %h for id %0d", nr, bus.resp_rdata, g[nr]); end
                nr++;
            end
            if (bus.p_req_ready && bus.d_req_ready) overlap++;
            if (ng < 8) begin
                if (bus.p_req_ready) begin g[ng] = 0; ng++; end
                else if (bus.d_req_ready) begin g[ng] = 1; ng++; end
            end else if (!bus.p_req_ready && !bus.d_req_ready) begin
                bus.p_req_valid = 1'b0;
                bus.d_req_valid = 1'b0;
            end
            if (nr == 8) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.p_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        n_checks++; if (nr !== 8) begin n_fail++; $display("FAIL arb_responses: got %0d expected 8", nr); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL arb_ready_overlap: got %0d cycles expected 0", overlap); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (g[k] !== k % 2) begin n_fail++; $display("FAIL arb_grant[%0d]: got %0d expected %0d", k, g[k], k % 2); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic err, rid; int lat; bit to; int w0;
        w0 = wr_count;
        run_req(1'b1, 2'b01, 12'hC00, 32'h1, rd, err, rid, lat, to);
        n_checks++; if (to || err !== 1'b1 || rid !== 1'b1 || rd !== 32'hC0DE_0C00) begin n_fail++; $display("FAIL ro_rw_resp: got to%b e%b id%b %h expected 0 1 1 c0de0c00", to, err, rid, rd); end
        n_checks++; if (wr_count - w0 !== 0 || rf[12'hC00] !== 32'hC0DE_0C00) begin n_fail++; $display("FAIL ro_rw_nowrite: got %0d writes rf %h expected 0 c0de0c00", wr_count - w0, rf[12'hC00]); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL ro_err_cnt: got %0d expected 1", err_cnt); end
        run_req(1'b1, 2'b10, 12'hC00, 32'h0, rd, err, rid, lat, to);
        n_checks++; if (to || err !== 1'b0 || wr_count - w0 !== 0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL ro_rs_zero: got to%b e%b %0d writes cnt %0d expected 0 0 0 1", to, err, wr_count - w0, err_cnt); end
        run_req(1'b0, 2'b00, 12'hC00, 32'h0, rd, err, rid, lat, to);
        n_checks++; if (to || err !== 1'b0 || rd !== 32'hC0DE_0C00) begin n_fail++; $display("FAIL ro_read: got to%b e%b %h expected 0 0 c0de0c00", to, err, rd); end
    endtask

    task automatic test_backpressure();
        bus.p_req_valid = 1'b1; bus.p_req_op = 2'b00; bus.p_req_addr = 12'h020; bus.p_req_wdata = '0;
        #1;
        n_checks++; if (bus.p_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b expected 1", bus.p_req_ready); end
        @(negedge clk);
        bus.p_req_valid = 1'b0;
        bus.d_req_valid = 1'b1; bus.d_req_op = 2'b00; bus.d_req_addr = 12'h010; bus.d_req_wdata = '0;
        #1;
        n_checks++; if (bus.d_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_busy_ready: got %b expected 0", bus.d_req_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h2222_0020 || bus.resp_id !== 1'b0 || bus.d_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h id%b dr%b expected 1 22220020 0 0", i, bus.resp_valid, bus.resp_rdata, bus.resp_id, bus.d_req_ready); end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bus.d_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got busy%b dr%b expected 0 1", busy, bus.d_req_ready); end
        @(negedge clk);
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_rdata !== 32'h1111_0010) begin n_fail++; $display("FAIL bp_dbg_resp: got v%b id%b %h expected 1 1 11110010", bus.resp_valid, bus.resp_id, bus.resp_rdata); end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] rd; logic err, rid; int lat; bit to; int w0; int tos = 0;
        w0 = wr_count;
        for (int i = 0; i < 260; i++) begin
            run_req(1'b0, 2'b01, 12'hC04, 32'h1, rd, err, rid, lat, to);
            if (to) tos++;
        end
        n_checks++; if (tos !== 0) begin n_fail++; $display("FAIL sat_timeouts: got %0d expected 0", tos); end
        n_checks++; if (err_cnt !== 8'd255 || wr_count - w0 !== 0) begin n_fail++; $display("FAIL sat_err_cnt: got %0d, %0d writes expected 255, 0", err_cnt, wr_count - w0); end
    endtask

    task automatic test_reset_abort();
        int w0; int seen = 0;
        bus.p_req_valid = 1'b1; bus.p_req_op = 2'b01; bus.p_req_addr = 12'h200; bus.p_req_wdata = 32'hAA;
        #1;
        n_checks++; if (bus.p_req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_accept: got %b expected 1", bus.p_req_ready); end
        @(negedge clk);
        bus.p_req_valid = 1'b0;
        n_checks++; if (bus.csr_wrt_en !== 1'b1) begin n_fail++; $display("FAIL abort_exec_we: got %b expected 1", bus.csr_wrt_en); end
        w0 = wr_count;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.csr_wrt_en !== 1'b0 || busy !== 1'b0 || bus.csr_din !== 32'h0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL abort_async: got we%b busy%b din %h cnt %0d expected 0 0 0 0", bus.csr_wrt_en, busy, bus.csr_din, err_cnt); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d cycles expected 0", seen); end
        n_checks++; if (rf[12'h200] !== 32'h55 || wr_count !== w0) begin n_fail++; $display("FAIL abort_no_write: got %h, %0d writes expected 00000055, 0", rf[12'h200], wr_count - w0); end
    endtask

    initial begin
        bus.p_req_valid = 1'b0; bus.p_req_op = '0; bus.p_req_addr = '0; bus.p_req_wdata = '0;
        bus.d_req_valid = 1'b0; bus.d_req_op = '0; bus.d_req_addr = '0; bus.d_req_wdata = '0;
        bus.resp_ready  = 1'b0;
        reset = 1'b0;
        preload(12'h010, 32'h1111_0010);
        preload(12'h020, 32'h2222_0020);
        preload(12'h300, 32'h0000_0008);
        preload(12'h100, 32'h0000_FFFF);
        preload(12'h200, 32'h0000_0055);
        preload(12'hC00, 32'hC0DE_0C00);
        preload(12'hC04, 32'h0000_0000);
        test_reset();
        test_rs_collision();
        test_ops();
        test_arbitration();
        test_illegal();
        test_backpressure();
        test_saturation();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, CSR address width.
REQ-002 Parameter DATA_W, default 32, CSR data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset==0 resets).
REQ-005 p_req_valid / d_req_valid  in  1 each  pipeline / debug request valid.
REQ-006 p_req_ready / d_req_ready  out  1 each  request accepted this cycle.
REQ-007 p_req_op / d_req_op  in  2 each  00=read, 01=RW, 10=RS (set), 11=RC (clear).
REQ-008 p_req_addr / d_req_addr  in  ADDR_W each  target CSR.
REQ-009 p_req_wdata / d_req_wdata  in  DATA_W each  write operand / mask.
REQ-010 resp_valid  out  1  response available; resp_ready  in  1  consumer accepts.
REQ-011 resp_id  out  1  0=pipeline, 1=debug; resp_rdata  out  DATA_W  old CSR value; resp_err  out  1  illegal write.
REQ-012 csr_addr  out  ADDR_W, csr_din  out  DATA_W, csr_wrt_en  out  1  drive register file.
REQ-013 csr_dout  in  DATA_W  combinational read data from register file.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err_cnt  out  8  saturating count of illegal-write responses.

Function
REQ-016 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP always, RESP->IDLE when resp_ready==1 while resp_valid==1.
REQ-017 Ready asserted only in IDLE, combinationally from valid; at most one ready high per cycle.
REQ-018 Both valid in IDLE: grant the requester not granted last; last-grant resets to debug so pipeline wins first conflict.
REQ-019 Single valid in IDLE: that requester granted regardless of last-grant.
REQ-020 On accept, latch op, addr, wdata, id; latched addr drives csr_addr from the next cycle onward.
REQ-021 EXEC lasts exactly one cycle: capture csr_dout into resp_rdata; compute new = wdata (RW), old|wdata (RS), old&~wdata (RC).
REQ-022 Write-enable condition: op==RW, or op in {RS,RC} with wdata!=0; op==read never writes.
REQ-023 Address with addr[11:10]==2'b11 is read-only: if REQ-022 holds, set resp_err=1, suppress write, increment err_cnt (saturate at 255).
REQ-024 csr_wrt_en high only in EXEC when write enabled and not illegal; exactly one cycle per access; csr_din = new value then.
REQ-025 resp_valid high throughout RESP; resp_id/rdata/err stable until handshake.
REQ-026 Accept-to-resp_valid latency 2 cycles; earliest back-to-back accept is the cycle after the handshake (3-cycle throughput).
REQ-027 Requests arriving while busy are not accepted; requester holds valid and payload.
REQ-028 Read of a CSR being written returns pre-write value (read and write occur in the same EXEC cycle).

Reset
REQ-029 reset==0 asynchronously forces: state IDLE, ready low, resp_valid 0, resp_id 0, resp_rdata 0, resp_err 0, csr_wrt_en 0, csr_addr 0, csr_din 0, busy 0, err_cnt 0, last-grant=debug.
REQ-030 Reset in EXEC or RESP aborts the access; no write issued, no response delivered after release.
REQ-031 First grant possible on the first rising edge with reset==1.

Verification
REQ-032 Regfile preloaded 0x300=0x0000_0008; pipeline RS addr 0x300 wdata 0x80 -> resp_rdata 0x08, err 0, one-cycle wrt_en with csr_din 0x88.
REQ-033 Both valid continuously, 4 accesses each -> grants alternate P,D,P,D...; resp_id matches; no ready overlap.
REQ-034 Debug RW addr 0xC00 wdata 0x1 -> resp_err 1, wrt_en never high, err_cnt 1; RS to 0xC00 with wdata 0 -> err 0, no write.
REQ-035 resp_ready held low 5 cycles -> resp_valid and payload stable, no new accept; after handshake next accept next cycle.
REQ-036 reset pulsed low during EXEC of RW -> wrt_en 0 immediately, CSR unchanged, resp_valid never asserted for that request.
